hazard_scoreboard: RTL and testbench

Parametrised stall/forward controller for the pipelined MIPS core, sitting beside the D-stage control decoder and consuming its per-instruction Tuse/Tnew, register-write and MDU fields. It tracks in-flight register writes across a configurable number of post-decode stages and counts down multiply/divide occupancy. It produces the D-stage stall, the E-stage bubble and per-operand forward selects. It generalises the fixed Tuse/Tnew comparison to per-operand Tuse, an arbitrary stage depth and a variable-latency MDU busy window.

---
 rtl/hazard_scoreboard_pkg.sv | 36 +++
 rtl/hazard_scoreboard_if.sv | 50 +++++
 rtl/hazard_scoreboard_md_busy_counter.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : hazard_pkg                                                    |
// | Description: Shared types and constants for the hazard scoreboard: stage   |
// |              codes for forward selects, the "operand unused" Tuse marker,  |
// |              default widths and the scoreboard slot record.                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package hazard_pkg;

    // Default configuration of the MIPS core this controller sits in
    localparam int unsigned STAGES_DEF = 3;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned T_W_DEF    = 2;
    localparam int unsigned MD_W_DEF   = 4;

    // Forward-select stage codes (0 = take the register file value)
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_stage_e;

    // A Tuse of all-ones marks an operand the instruction does not read
    localparam logic [T_W_DEF-1:0] TUSE_NONE = '1;

    // One in-flight register write at the default widths
    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] wreg;
        logic [T_W_DEF-1:0]   tnew;
    } slot_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : hazard_scoreboard_if                                          |
// | Description: D-stage decode fields into the scoreboard and the stall /     |
// |              bubble / forward / MDU-busy controls back to the pipeline.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int T_W    = T_W_DEF,
    parameter int MD_W   = MD_W_DEF
);
    localparam int FWD_W = $clog2(STAGES + 1);

    logic             clr;
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic [T_W-1:0]   d_tuse_rs;
    logic [T_W-1:0]   d_tuse_rt;
    logic             d_regwrite;
    logic [REG_W-1:0] d_wreg;
    logic [T_W-1:0]   d_tnew;
    logic             d_md_start;
    logic [MD_W-1:0]  d_md_time;
    logic             d_md_use;
    logic             stall;
    logic             bubble_e;
    logic [FWD_W-1:0] fwd_rs;
    logic [FWD_W-1:0] fwd_rt;
    logic             md_busy;

    // Decoder / pipeline side
    modport master (
        output clr, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_wreg,
               d_tnew, d_md_start, d_md_time, d_md_use,
        input  stall, bubble_e, fwd_rs, fwd_rt, md_busy
    );

    // Scoreboard side
    modport slave (
        input  clr, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_wreg,
               d_tnew, d_md_start, d_md_time, d_md_use,
        output stall, bubble_e, fwd_rs, fwd_rt, md_busy
    );

endinterface : hazard_scoreboard_if
`default_nettype wire

// File: rtl/hazard_scoreboard_md_busy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : md_busy_counter                                               |
// | Description: Multiply/divide occupancy counter. Loads the operation's      |
// |              latency on issue, counts down to zero, flags busy while       |
// |              non-zero.                                                     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MD_W = MD_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic [MD_W-1:0] time_i,
    output logic            busy_o
);

    logic [MD_W-1:0] cnt_q;
    logic [MD_W-1:0] cnt_d;

    // A new issue overrides any residual count; otherwise drain toward zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = time_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MD_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule : md_busy_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hazard_scoreboard                                             |
// | Description: Stall/forward controller. Tracks in-flight GPR writes over    |
// |              STAGES post-decode stages with per-slot Tnew, compares them   |
// |              against per-operand Tuse, and adds an MDU busy window.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int T_W    = T_W_DEF,
    parameter int MD_W   = MD_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    hazard_scoreboard_if.slave hz
);

    localparam int FWD_W = $clog2(STAGES + 1);

    // Slot record at this instance's widths (slot 1 = E, slot STAGES = oldest)
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wreg;
        logic [T_W-1:0]   tnew;
    } sb_slot_t;

    sb_slot_t [STAGES:1] slot_q;
    sb_slot_t [STAGES:1] slot_d;
    logic     [STAGES:1] hit_rs;
    logic     [STAGES:1] hit_rt;

    logic             found_rs, found_rt;
    logic [T_W-1:0]   tnew_rs, tnew_rt;
    logic [FWD_W-1:0] sel_rs, sel_rt;
    logic             stall_rs, stall_rt;
    logic             md_busy;
    logic             stall;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    // Per-slot match against the D sources and next-state shift; $0 never matches
    for (genvar k = 1; k <= STAGES; k++) begin : g_slot
        assign hit_rs[k] = slot_q[k].valid && (slot_q[k].wreg == hz.d_rs) && (hz.d_rs != '0);
        assign hit_rt[k] = slot_q[k].valid && (slot_q[k].wreg == hz.d_rt) && (hz.d_rt != '0);

        if (k == 1) begin : g_head
            // A stalled D cycle injects a bubble; clr wins over a real issue
            assign slot_d[k] = (hz.clr || stall) ? '0 :
                sb_slot_t'{valid: hz.d_regwrite && (hz.d_wreg != '0),
                           wreg:  hz.d_wreg,
                           tnew:  sat_dec(hz.d_tnew)};
        end else begin : g_shift
            assign slot_d[k] = hz.clr ? '0 :
                sb_slot_t'{valid: slot_q[k-1].valid,
                           wreg:  slot_q[k-1].wreg,
                           tnew:  sat_dec(slot_q[k-1].tnew)};
        end
    end

    // Youngest-match priority: scan oldest to youngest so the lowest slot wins
    always_comb begin
        found_rs = 1'b0;
        found_rt = 1'b0;
        tnew_rs  = '0;
        tnew_rt  = '0;
        sel_rs   = '0;
        sel_rt   = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hit_rs[k]) begin
                found_rs = 1'b1;
                tnew_rs  = slot_q[k].tnew;
                sel_rs   = FWD_W'(k);
            end
            if (hit_rt[k]) begin
                found_rt = 1'b1;
                tnew_rt  = slot_q[k].tnew;
                sel_rt   = FWD_W'(k);
            end
        end
    end

    // Unused operands (Tuse all-ones) can never stall
    assign stall_rs = found_rs && (hz.d_tuse_rs != '1) && (tnew_rs > hz.d_tuse_rs);
    assign stall_rt = found_rt && (hz.d_tuse_rt != '1) && (tnew_rt > hz.d_tuse_rt);
    assign stall    = stall_rs || stall_rt || (hz.d_md_use && md_busy);

    assign hz.stall    = stall;
    assign hz.bubble_e = stall;
    assign hz.fwd_rs   = (found_rs && (tnew_rs == '0)) ? sel_rs : '0;
    assign hz.fwd_rt   = (found_rt && (tnew_rt == '0)) ? sel_rt : '0;
    assign hz.md_busy  = md_busy;

    // Scoreboard slot registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    md_busy_counter #(
        .MD_W (MD_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (!stall && hz.d_md_start),
        .time_i  (hz.d_md_time),
        .busy_o  (md_busy)
    );

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_hazard_scoreboard                                          |
// | Description: Self-checking bench. A driver issues directed and random D    |
// |              instructions, predicts outputs from an age-based model of    |
// |              in-flight writes and pushes them to a queue; a monitor pops   |
// |              and compares on every falling edge.                           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int STAGES = 3;
    localparam int REG_W  = 5;
    localparam int T_W    = 2;
    localparam int MD_W   = 4;
    localparam int FWD_W  = $clog2(STAGES + 1);
    localparam int UNUSED = (1 << T_W) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STAGES(STAGES), .REG_W(REG_W), .T_W(T_W), .MD_W(MD_W)) hz ();

    hazard_scoreboard #(.STAGES(STAGES), .REG_W(REG_W), .T_W(T_W), .MD_W(MD_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    typedef struct {
        logic [REG_W-1:0] rs, rt, wreg;
        logic [T_W-1:0]   tuse_rs, tuse_rt, tnew;
        logic             regwrite, md_start, md_use, clr, rst_n;
        logic [MD_W-1:0]  md_time;
    } stim_t;

    typedef struct packed {
        logic             stall;
        logic             bubble;
        logic [FWD_W-1:0] fwd_rs;
        logic [FWD_W-1:0] fwd_rt;
        logic             md_busy;
    } exp_t;

    typedef struct { int wreg; int tnew; int issue; } rec_t;

    exp_t exp_q[$];
    rec_t inflight[$];
    int   cyc    = 1;
    int   md_end = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    // ---------------- reference model ----------------
    // A write issued at cycle c sits at age a = now - c (1..STAGES) with
    // max(tnew - a, 0) cycles still to go before its value exists.
    function automatic void resolve(input int src, input int tuse, output bit st, output int fwd);
        int best = 0;
        int rem  = 0;
        foreach (inflight[i]) begin
            int age = cyc - inflight[i].issue;
            if (src != 0 && inflight[i].wreg == src && age >= 1 && age <= STAGES &&
                (best == 0 || age < best)) begin
                best = age;
                rem  = (inflight[i].tnew > age) ? inflight[i].tnew - age : 0;
            end
        end
        st  = (best != 0) && (tuse != UNUSED) && (rem > tuse);
        fwd = (best != 0 && rem == 0) ? best : 0;
    endfunction

    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        bit   st_rs, st_rt;
        int   f_rs, f_rt;
        resolve(int'(s.rs), int'(s.tuse_rs), st_rs, f_rs);
        resolve(int'(s.rt), int'(s.tuse_rt), st_rt, f_rt);
        e.md_busy = (cyc <= md_end);
        e.stall   = st_rs || st_rt || (s.md_use && e.md_busy);
        e.bubble  = e.stall;
        e.fwd_rs  = FWD_W'(f_rs);
        e.fwd_rt  = FWD_W'(f_rt);
        return e;
    endfunction

    task automatic model_reset();
        inflight.delete();
        md_end = cyc - 1;
    endtask

    task automatic model_commit(input stim_t s, input bit st);
        if (s.rst_n) begin
            if (s.clr) inflight.delete();
            else if (!st && s.regwrite && s.wreg != 0)
                inflight.push_back('{wreg: int'(s.wreg), tnew: int'(s.tnew), issue: cyc});
            if (!st && s.md_start) md_end = cyc + int'(s.md_time);
        end
        cyc++;
        while (inflight.size() > 0 && cyc - inflight[0].issue > STAGES) void'(inflight.pop_front());
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one predicted response per cycle, compared mid-cycle
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got.stall   = hz.stall;
                got.bubble  = hz.bubble_e;
                got.fwd_rs  = hz.fwd_rs;
                got.fwd_rt  = hz.fwd_rt;
                got.md_busy = hz.md_busy;
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL monitor t=%0t: got stall=%0b bubble=%0b fwd_rs=%0d fwd_rt=%0d busy=%0b, expected stall=%0b bubble=%0b fwd_rs=%0d fwd_rt=%0d busy=%0b",
                             $time, got.stall, got.bubble, got.fwd_rs, got.fwd_rt, got.md_busy,
                             e.stall, e.bubble, e.fwd_rs, e.fwd_rt, e.md_busy);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic stim_t nop();
        stim_t s;
        s.rs = '0; s.rt = '0; s.wreg = '0;
        s.tuse_rs = '1; s.tuse_rt = '1; s.tnew = '0;
        s.regwrite = 1'b0; s.md_start = 1'b0; s.md_use = 1'b0;
        s.clr = 1'b0; s.rst_n = 1'b1; s.md_time = '0;
        return s;
    endfunction

    function automatic stim_t wr(input int wreg, input int tnew);
        stim_t s = nop();
        s.regwrite = 1'b1; s.wreg = REG_W'(wreg); s.tnew = T_W'(tnew);
        return s;
    endfunction

    function automatic stim_t rd(input int rs, input int tuse);
        stim_t s = nop();
        s.rs = REG_W'(rs); s.tuse_rs = T_W'(tuse);
        return s;
    endfunction

    // One D cycle: drive at posedge+1, predict, sample DUT directly, commit at edge
    task automatic step(input stim_t s, output bit mst, output exp_t obs);
        exp_t e;
        reset_n       = s.rst_n;
        hz.clr        = s.clr;
        hz.d_rs       = s.rs;
        hz.d_rt       = s.rt;
        hz.d_tuse_rs  = s.tuse_rs;
        hz.d_tuse_rt  = s.tuse_rt;
        hz.d_regwrite = s.regwrite;
        hz.d_wreg     = s.wreg;
        hz.d_tnew     = s.tnew;
        hz.d_md_start = s.md_start;
        hz.d_md_time  = s.md_time;
        hz.d_md_use   = s.md_use;
        if (!s.rst_n) model_reset();
        e = model_expect(s);
        exp_q.push_back(e);
        mst = e.stall;
        #2;
        obs.stall   = hz.stall;
        obs.bubble  = hz.bubble_e;
        obs.fwd_rs  = hz.fwd_rs;
        obs.fwd_rt  = hz.fwd_rt;
        obs.md_busy = hz.md_busy;
        @(posedge clk);
        model_commit(s, e.stall);
        #1;
    endtask

    task automatic go(input stim_t s);
        bit   m;
        exp_t o;
        step(s, m, o);
    endtask

    task automatic drain();
        repeat (STAGES + 1) go(nop());
    endtask

    // Hold an instruction in D until the model lets it issue; count DUT stall cycles
    task automatic hold_issue(input string name, input stim_t s, input int req_stalls, input int req_fwd);
        bit   m;
        exp_t o;
        int   stalls = 0;
        int   n      = 0;
        do begin
            step(s, m, o);
            if (o.stall) stalls++;
            n++;
        end while (m && n < 40);
        if (m) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: still stalled after %0d cycles, expected issue", name, n);
        end
        check({name, " stalls"}, stalls, req_stalls);
        check({name, " fwd_rs"}, int'(o.fwd_rs), req_fwd);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit    m;
        exp_t  o;
        stim_t s;
        int    busy_cnt;

        s = nop(); s.rst_n = 1'b0;
        hz.clr = 1'b0; hz.d_rs = '0; hz.d_rt = '0; hz.d_tuse_rs = '1; hz.d_tuse_rt = '1;
        hz.d_regwrite = 1'b0; hz.d_wreg = '0; hz.d_tnew = '0; hz.d_md_start = 1'b0;
        hz.d_md_time = '0; hz.d_md_use = 1'b0;
        @(posedge clk); #1;

        // Reset state with a would-be hazard on the inputs
        s = rd(1, 0); s.md_use = 1'b1; s.rst_n = 1'b0;
        step(s, m, o);
        check("reset stall", int'(o.stall), 0);
        check("reset md_busy", int'(o.md_busy), 0);
        go(nop());

        // lw $1 -> add using $1 at Tuse 1
        go(wr(1, 3));
        hold_issue("lw-add", rd(1, 1), 1, 0);
        drain();

        // addu $2 -> beq $2
        go(wr(2, 2));
        hold_issue("addu-beq", rd(2, 0), 1, 2);
        drain();

        // lw $3 -> beq $3
        go(wr(3, 3));
        hold_issue("lw-beq", rd(3, 0), 2, 3);
        drain();

        // Writes to $0 are never tracked
        go(wr(0, 3));
        hold_issue("zero-reg", rd(0, 0), 0, 0);
        drain();

        // $5 written by an older addu (now in M) and a younger lw (in E)
        go(wr(5, 1));
        go(wr(5, 3));
        hold_issue("E-over-M", rd(5, 0), 2, 3);
        drain();

        // mult (5) then mfhi, then div (10) and count its busy window
        s = nop(); s.md_start = 1'b1; s.md_use = 1'b1; s.md_time = MD_W'(5);
        go(s);
        s = nop(); s.md_use = 1'b1;
        hold_issue("mult-mfhi", s, 5, 0);
        s = nop(); s.md_start = 1'b1; s.md_use = 1'b1; s.md_time = MD_W'(10);
        hold_issue("div issue", s, 0, 0);
        busy_cnt = 0;
        repeat (12) begin
            step(nop(), m, o);
            if (o.md_busy) busy_cnt++;
        end
        check("div busy cycles", busy_cnt, 10);

        // Async reset mid-busy: outputs drop before the next edge
        s = nop(); s.md_start = 1'b1; s.md_use = 1'b1; s.md_time = MD_W'(10);
        go(s);
        go(nop());
        s = nop(); s.md_use = 1'b1; s.rst_n = 1'b0;
        step(s, m, o);
        check("rst mid-busy stall", int'(o.stall), 0);
        check("rst mid-busy md_busy", int'(o.md_busy), 0);
        hold_issue("post-rst add", rd(9, 1), 0, 0);

        // Async reset during a lw stall
        go(wr(7, 3));
        step(rd(7, 0), m, o);
        check("lw stall before rst", int'(o.stall), 1);
        s = rd(7, 0); s.rst_n = 1'b0;
        step(s, m, o);
        check("rst mid-stall stall", int'(o.stall), 0);
        check("rst mid-stall bubble", int'(o.bubble), 0);
        hold_issue("post-rst add2", rd(8, 1), 0, 0);
        drain();

        // clr while lw $4 sits in E
        go(wr(4, 3));
        s = nop(); s.clr = 1'b1;
        go(s);
        hold_issue("clr", rd(4, 0), 0, 0);
        drain();

        // Randomised traffic over a small register set
        for (int i = 0; i < 600; i++) begin
            s.rs       = REG_W'($urandom_range(0, 7));
            s.rt       = REG_W'($urandom_range(0, 7));
            s.tuse_rs  = T_W'($urandom_range(0, 3));
            s.tuse_rt  = T_W'($urandom_range(0, 3));
            s.regwrite = 1'($urandom_range(0, 1));
            s.wreg     = REG_W'($urandom_range(0, 7));
            s.tnew     = T_W'($urandom_range(0, 3));
            s.md_start = ($urandom_range(0, 7) == 0);
            s.md_time  = MD_W'($urandom_range(0, 15));
            s.md_use   = s.md_start || ($urandom_range(0, 5) == 0);
            s.clr      = ($urandom_range(0, 19) == 0);
            s.rst_n    = ($urandom_range(0, 99) != 0);
            go(s);
        end
        go(nop());

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
